// File: rtl/serial_tx_arbiter.sv
// Round-robin arbiter in front of a single MSB-first serializer.
// One requester at a time owns the line for DW*CLKS_PER_BIT cycles, then
// receives a one-cycle done pulse; the search pointer then advances past it.
module serial_tx_arbiter #(
    parameter int unsigned NREQ         = 4,
    parameter int unsigned DW           = 8,
    parameter int unsigned CLKS_PER_BIT = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NREQ-1:0]    req,
    input  logic [NREQ*DW-1:0] din,
    output logic [NREQ-1:0]    gnt,
    output logic [NREQ-1:0]    done,
    output logic               dout,
    output logic               dout_vld,
    output logic               busy
);

    localparam int unsigned PW  = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int unsigned PW1 = PW + 1;
    localparam int unsigned CW  = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int unsigned BW  = (DW > 1) ? $clog2(DW) : 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    logic [1:0]    state;
    logic [1:0]    state_nxt;
    logic [PW-1:0] ptr;
    logic [PW-1:0] cur;
    logic [DW-1:0] shreg;
    logic [BW-1:0] bit_cnt;
    logic [CW-1:0] sub_cnt;

    logic          win_found;
    logic [PW-1:0] win_idx;
    logic [PW:0]   idx_sum;
    logic [DW-1:0] win_data;
    logic          sub_wrap;
    logic          last_bit;

    assign sub_wrap = (sub_cnt == CW'(CLKS_PER_BIT - 1));
    assign last_bit = (bit_cnt == BW'(DW - 1));

    // Round-robin search: first asserted req at or above ptr, wrapping to 0.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        idx_sum   = '0;
        for (int k = 0; k < int'(NREQ); k++) begin
            idx_sum = {1'b0, ptr} + PW1'(k);
            if (idx_sum >= PW1'(NREQ)) begin
                idx_sum = idx_sum - PW1'(NREQ);
            end
            if (!win_found && req[idx_sum[PW-1:0]]) begin
                win_found = 1'b1;
                win_idx   = idx_sum[PW-1:0];
            end
        end
        win_data = din[32'(win_idx) * DW +: DW];
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: IDLE -> SHIFT on any request, SHIFT -> DONE after the
    // final sub-bit of the last bit, DONE always returns to IDLE.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (win_found) begin
                    state_nxt = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (sub_wrap && last_bit) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Grant capture, shift/count datapath, done pulse and pointer advance.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gnt     <= '0;
            done    <= '0;
            ptr     <= '0;
            cur     <= '0;
            shreg   <= '0;
            bit_cnt <= '0;
            sub_cnt <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    done <= '0;
                    if (win_found) begin
                        gnt     <= NREQ'(1) << win_idx;
                        cur     <= win_idx;
                        shreg   <= win_data;
                        bit_cnt <= '0;
                        sub_cnt <= '0;
                    end
                end
                S_SHIFT: begin
                    if (sub_wrap) begin
                        sub_cnt <= '0;
                        if (last_bit) begin
                            gnt  <= '0;
                            done <= NREQ'(1) << cur;
                        end else begin
                            shreg   <= {shreg[DW-2:0], 1'b0};
                            bit_cnt <= bit_cnt + BW'(1);
                        end
                    end else begin
                        sub_cnt <= sub_cnt + CW'(1);
                    end
                end
                S_DONE: begin
                    done <= '0;
                    ptr  <= (cur == PW'(NREQ - 1)) ? '0 : cur + PW'(1);
                end
                default: begin
                    gnt  <= '0;
                    done <= '0;
                end
            endcase
        end
    end

    // Line outputs decoded from registered state; dout forced low off-frame.
    assign dout_vld = (state == S_SHIFT);
    assign dout     = dout_vld & shreg[DW-1];
    assign busy     = (state != S_IDLE);

endmodule
